// File: rtl/multicycle_alu.sv
// multicycle_alu
//   Multi-cycle execution unit fed by the ALU control decoder. Logic, arithmetic
//   and compare operations complete in one cycle. Shifts move the operand one
//   bit position per cycle, so no barrel shifter is needed. Results return over
//   a valid/ready handshake and stay registered until the consumer takes them.
//
//   Operation codes (shared operation-type constants):
//     0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 LESS_THAN (signed),
//     6 LEFT_SHIFT, 7 RIGHT_SHIFT, 8 SIGNED_RIGHT_SHIFT.
//     Any other code produces a result of 0.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  unit can accept a request (state IDLE)
//   op         in   4-bit operation code
//   a          in   operand A
//   b          in   operand B; shifts use only b[SHW-1:0]
//   rsp_valid  out  result available (state DONE)
//   rsp_ready  in   consumer takes the result
//   result     out  registered result
//   zero       out  registered (result == 0), updated together with result
module multicycle_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_XOR  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;

  logic [WIDTH-1:0]   alu_out;
  logic               is_shift;
  logic [WIDTH-1:0]   shifted;

  // Single-cycle datapath on the live request operands.
  always_comb begin
    alu_out = '0;
    unique case (op)
      OP_ADD:  alu_out = a + b;
      OP_SUB:  alu_out = a - b;
      OP_XOR:  alu_out = a ^ b;
      OP_OR:   alu_out = a | b;
      OP_AND:  alu_out = a & b;
      OP_SLT:  alu_out[0] = ($signed(a) < $signed(b));
      default: alu_out = '0;
    endcase
  end

  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // One-position shift of the accumulator, direction taken from the latched op.
  always_comb begin
    shifted = '0;
    unique case (op_q)
      OP_SLL:  shifted = {acc_q[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc_q[WIDTH-1:1]};
      default: shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    count_d  = count_q;
    result_d = result_q;
    zero_d   = zero_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d = op;
          if (is_shift) begin
            acc_d   = a;
            count_d = b[SHW-1:0];
            if (b[SHW-1:0] == '0) begin
              result_d = a;
              zero_d   = (a == '0);
              state_d  = DONE;
            end else begin
              state_d = SHIFT;
            end
          end else begin
            result_d = alu_out;
            zero_d   = (alu_out == '0);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        acc_d   = shifted;
        count_d = count_q - SHW'(1);
        if (count_q == SHW'(1)) begin
          result_d = shifted;
          zero_d   = (shifted == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE first enforces one idle cycle before the next accept.
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
module tb_multicycle_alu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] result;
  logic        zero;

  int passed = 0;
  int total  = 0;

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, OR = 4'd3, AND = 4'd4,
                         SLT = 4'd5, SLL = 4'd6, SRL = 4'd7, SRA = 4'd8;

  multicycle_alu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .op(op), .a(a), .b(b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .result(result), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, measure latency to rsp_valid, check result, then drain.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_res,
                        input logic exp_zero, input int exp_lat);
    int lat;
    check({tag, " req_ready"}, 32'(req_ready), 32'd1);
    op = o; a = va; b = vb; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 4'hF;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " result"}, result, exp_res);
    check({tag, " zero"}, 32'(zero), 32'(exp_zero));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, " idle after rsp"}, {30'd0, rsp_valid, req_ready}, 32'b01);
  endtask

  initial begin
    int saw_valid;
    logic [31:0] held_res;
    logic        held_zero;

    // Reset, then a mid-cycle re-assert must act immediately.
    tick(); tick();
    reset = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    check("reset outputs", {rsp_valid, req_ready, zero, result[28:0]}, 32'h4000_0000);
    check("reset result", result, 32'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    check("idle after reset", {rsp_valid, req_ready, zero, result[28:0]}, 32'h4000_0000);

    // Single-cycle operations
    run_op("add wrap",   ADD, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b1, 1);
    run_op("sub",        SUB, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1);
    run_op("slt true",   SLT, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1);
    run_op("slt false",  SLT, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b1, 1);
    run_op("and",        AND, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1);
    run_op("or",         OR,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 1'b0, 1);
    run_op("xor",        XOR, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0, 1);
    run_op("unlisted",   4'hF, 32'h1234_5678, 32'h1,        32'h0,         1'b1, 1);

    // Shifts
    run_op("sll 31",     SLL, 32'h1,         32'd31,        32'h8000_0000, 1'b0, 32);
    run_op("sra 4",      SRA, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 5);
    run_op("srl 4",      SRL, 32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 5);
    run_op("sll b=0x25", SLL, 32'h1,         32'h25,        32'h0000_0020, 1'b0, 6);
    run_op("srl 0",      SRL, 32'h1234,      32'd0,         32'h0000_1234, 1'b0, 1);
    run_op("srl to 0",   SRL, 32'h1,         32'd1,         32'h0,         1'b1, 2);

    // Backpressure: result held, inputs ignored, no accept during handshake.
    op = SUB; a = 32'd5; b = 32'd7; req_valid = 1'b1;
    tick();
    check("bp rsp_valid", 32'(rsp_valid), 32'd1);
    held_res = result;
    held_zero = zero;
    check("bp first result", held_res, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      op = 4'(i); a = $urandom; b = $urandom; req_valid = 1'b1;
      tick();
    end
    check("bp result held", result, 32'hFFFF_FFFE);
    check("bp zero held", 32'(zero), 32'(held_zero));
    check("bp flags", {30'd0, rsp_valid, req_ready}, 32'b10);
    op = ADD; a = 32'd1; b = 32'd1;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp no accept on handshake", {30'd0, rsp_valid, req_ready}, 32'b01);
    req_valid = 1'b0;
    tick();
    check("bp still idle", {30'd0, rsp_valid, req_ready}, 32'b01);

    // Reset mid-shift discards the operation.
    op = SLL; a = 32'h1; b = 32'd20; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    check("midshift busy", {30'd0, rsp_valid, req_ready}, 32'b00);
    #2 reset = 1'b1;
    #1;
    check("midshift reset flags", {30'd0, rsp_valid, req_ready}, 32'b01);
    tick();
    reset = 1'b0;
    saw_valid = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (rsp_valid) saw_valid++;
    end
    check("midshift no response", 32'(saw_valid), 32'd0);
    run_op("add after reset", ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
